// File: rtl/mioc_top.sv
`timescale 1ns/1ps
// mioc_top: memory / IO controller for the ADAM Z80 board.
//   Clock/reset : B_PHI (rising edge), RESET (async, active high).
//   Reset reqs  : N_CVRST (game reset), PBRST_N (computer reset), both active low.
//   Z80 bus     : BA15/14/13/7/6 address, BD0..BD3 data, N_BWR/BRD_N/BMREQ_N/
//                 IORQ_N/BRFSH_N/BM1_N/WAIT_N strobes (active low).
//   DMA/6801    : DMA_N, BUSAK_N, OS3_N in; BUSRQ_N, ADDRBUFEN_N, IS3_N out.
//   Resets out  : RST_N, CPRST_N (system), NETRST_N (AdamNET), active low.
//   Selects     : BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N (OS7), SPINDIS_N.
//   DRAM        : RAS_N, CAS1_N (lower 32K), CAS2_N (upper 32K), MUX, RA7.
module mioc_top #(
  parameter int RST_STRETCH = 4
) (
  input  logic B_PHI,
  input  logic RESET,
  input  logic N_CVRST,
  input  logic PBRST_N,
  input  logic BA15,
  input  logic BA14,
  input  logic BA13,
  input  logic BA7,
  input  logic BA6,
  input  logic BD0,
  input  logic BD1,
  input  logic BD2,
  input  logic BD3,
  input  logic N_BWR,
  input  logic BRD_N,
  input  logic BMREQ_N,
  input  logic IORQ_N,
  input  logic BRFSH_N,
  input  logic BM1_N,
  input  logic WAIT_N,
  input  logic DMA_N,
  input  logic BUSAK_N,
  input  logic OS3_N,
  output logic RST_N,
  output logic CPRST_N,
  output logic NETRST_N,
  output logic BUSRQ_N,
  output logic ADDRBUFEN_N,
  output logic SPINDIS_N,
  output logic IS3_N,
  output logic BOOTROMCS_N,
  output logic AUXROMCS_N,
  output logic AUXDECODE1_N,
  output logic EN245_N,
  output logic RAS_N,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic MUX,
  output logic RA7
);

  localparam int CNT_W = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_STRETCH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] sys_cnt_r, net_cnt_r;
  logic [3:0]       memmap_r;
  logic             spindis_n_r, is3_n_r, busrq_n_r, mux_r;
  logic             sys_src_s, net_src_s, rst_n_s, net_rst_n_s;
  logic             iow_s, mreq_s, refresh_s, ras_n_s, cas_rw_s;
  logic             sel_boot_s, sel_ram_s, sel_aux1_s, sel_auxrom_s, sel_en245_s;
  logic             unused_s;

  // WAIT_N is part of the bus but plays no role in decode or DRAM timing.
  assign unused_s = WAIT_N;

  // Reset sources; the raw sources feed the outputs directly so assertion is immediate.
  assign sys_src_s   = RESET | ~N_CVRST | ~PBRST_N;
  assign net_src_s   = RESET | ~PBRST_N;
  assign rst_n_s     = ~(sys_src_s | (sys_cnt_r != CNT_ZERO));
  assign net_rst_n_s = ~(net_src_s | (net_cnt_r != CNT_ZERO));

  assign iow_s     = ~IORQ_N & ~N_BWR & BM1_N;
  assign mreq_s    = ~BMREQ_N & BRFSH_N;
  assign refresh_s = ~BMREQ_N & ~BRFSH_N;

  // System reset stretch counter: reload while any source is active, then count down.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      sys_cnt_r <= CNT_LOAD;
    end else if (!N_CVRST || !PBRST_N) begin
      sys_cnt_r <= CNT_LOAD;
    end else if (sys_cnt_r != CNT_ZERO) begin
      sys_cnt_r <= sys_cnt_r - CNT_ONE;
    end else begin
      sys_cnt_r <= sys_cnt_r;
    end
  end

  // AdamNET reset stretch counter: the game reset does not disturb the network.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      net_cnt_r <= CNT_LOAD;
    end else if (!PBRST_N) begin
      net_cnt_r <= CNT_LOAD;
    end else if (net_cnt_r != CNT_ZERO) begin
      net_cnt_r <= net_cnt_r - CNT_ONE;
    end else begin
      net_cnt_r <= net_cnt_r;
    end
  end

  // Memory-map register: cleared while the system is in reset, writes ignored then.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      memmap_r <= 4'b0000;
    end else if (!rst_n_s) begin
      memmap_r <= 4'b0000;
    end else if (iow_s && !BA7 && BA6) begin
      memmap_r <= {BD3, BD2, BD1, BD0};
    end else begin
      memmap_r <= memmap_r;
    end
  end

  // Bus request follows DMA_N one edge late; any reset aborts the request.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      busrq_n_r <= 1'b1;
    end else if (!rst_n_s) begin
      busrq_n_r <= 1'b1;
    end else begin
      busrq_n_r <= DMA_N;
    end
  end

  // Spinner disable: port 0x80-class write clears it, 0xC0-class write sets it.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      spindis_n_r <= 1'b1;
    end else if (iow_s && BA7) begin
      spindis_n_r <= BA6;
    end else begin
      spindis_n_r <= spindis_n_r;
    end
  end

  // IS3 handshake: a Z80 write raises it, 6801 OS3 acknowledges; acknowledge wins.
  always_ff @(posedge B_PHI or posedge RESET) begin
    if (RESET) begin
      is3_n_r <= 1'b1;
    end else if (!OS3_N) begin
      is3_n_r <= 1'b1;
    end else if (iow_s && !BA7 && !BA6) begin
      is3_n_r <= 1'b0;
    end else begin
      is3_n_r <= is3_n_r;
    end
  end

  // Memory decode: each 32K half is mapped by its own two MEMMAP bits.
  always_comb begin
    sel_boot_s   = 1'b0;
    sel_ram_s    = 1'b0;
    sel_aux1_s   = 1'b0;
    sel_auxrom_s = 1'b0;
    sel_en245_s  = 1'b0;
    if (mreq_s) begin
      if (!BA15) begin
        case (memmap_r[1:0])
          2'b00: begin
            // Boot ROM covers 0x0000-0x5FFF, RAM the top 8K of the lower half.
            if (BA14 && BA13) begin
              sel_ram_s = 1'b1;
            end else begin
              sel_boot_s = 1'b1;
            end
          end
          2'b01: sel_ram_s  = 1'b1;
          2'b10: sel_aux1_s = 1'b1;
          2'b11: begin
            // OS7 sits in the bottom 8K, RAM fills the remainder.
            if (!BA14 && !BA13) begin
              sel_en245_s = 1'b1;
            end else begin
              sel_ram_s = 1'b1;
            end
          end
          default: sel_ram_s = 1'b0;
        endcase
      end else begin
        case (memmap_r[3:2])
          2'b00:   sel_ram_s    = 1'b1;
          2'b01:   sel_aux1_s   = 1'b1;
          2'b10:   sel_auxrom_s = 1'b1;
          2'b11:   sel_en245_s  = 1'b1;
          default: sel_ram_s    = 1'b0;
        endcase
      end
    end else begin
      sel_ram_s = 1'b0;
    end
  end

  // Refresh cycles strobe RAS on both banks regardless of the map.
  assign ras_n_s = ~(sel_ram_s | refresh_s);

  // Address mux: set on the first edge of an internal RAM access, dropped as soon as MREQ ends.
  always_ff @(posedge B_PHI or posedge RESET or posedge BMREQ_N) begin
    if (RESET) begin
      mux_r <= 1'b0;
    end else if (BMREQ_N) begin
      mux_r <= 1'b0;
    end else if (!ras_n_s && BRFSH_N) begin
      mux_r <= 1'b1;
    end else begin
      mux_r <= mux_r;
    end
  end

  assign cas_rw_s = ~BRD_N | ~N_BWR;

  assign RST_N        = rst_n_s;
  assign CPRST_N      = rst_n_s;
  assign NETRST_N     = net_rst_n_s;
  assign BUSRQ_N      = busrq_n_r;
  assign ADDRBUFEN_N  = ~BUSAK_N;
  assign SPINDIS_N    = spindis_n_r;
  assign IS3_N        = is3_n_r;
  assign BOOTROMCS_N  = ~sel_boot_s;
  assign AUXROMCS_N   = ~sel_auxrom_s;
  assign AUXDECODE1_N = ~sel_aux1_s;
  assign EN245_N      = ~sel_en245_s;
  assign RAS_N        = ras_n_s;
  assign MUX          = mux_r;
  // Row address bit 7 carries BA7, column bit carries BA15 once the mux has switched.
  assign RA7          = mux_r ? BA15 : BA7;
  // BRFSH_N gate keeps CAS quiet during refresh.
  assign CAS1_N       = ~(mux_r & BRFSH_N & ~BA15 & cas_rw_s);
  assign CAS2_N       = ~(mux_r & BRFSH_N & BA15 & cas_rw_s);

endmodule

// File: tb/tb_mioc_top.sv
`timescale 1ns/1ps
module tb_mioc_top;

  localparam int STRETCH = 4;
  localparam int S_NONE = 0, S_BOOT = 1, S_RAM = 2, S_AUX1 = 3, S_AUXROM = 4, S_EN245 = 5;

  logic B_PHI, RESET, N_CVRST, PBRST_N;
  logic BA15, BA14, BA13, BA7, BA6, BD0, BD1, BD2, BD3;
  logic N_BWR, BRD_N, BMREQ_N, IORQ_N, BRFSH_N, BM1_N, WAIT_N;
  logic DMA_N, BUSAK_N, OS3_N;
  logic RST_N, CPRST_N, NETRST_N, BUSRQ_N, ADDRBUFEN_N, SPINDIS_N, IS3_N;
  logic BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N;
  logic RAS_N, CAS1_N, CAS2_N, MUX, RA7;

  int n_pass = 0;
  int n_total = 0;

  // Reference state kept at the level of "what the software last wrote".
  int mm_model = 0;
  bit spin_model = 1'b1;
  bit is3_model = 1'b1;
  bit rst_ok = 1'b1;

  mioc_top #(.RST_STRETCH(STRETCH)) dut (
    .B_PHI(B_PHI), .RESET(RESET), .N_CVRST(N_CVRST), .PBRST_N(PBRST_N),
    .BA15(BA15), .BA14(BA14), .BA13(BA13), .BA7(BA7), .BA6(BA6),
    .BD0(BD0), .BD1(BD1), .BD2(BD2), .BD3(BD3),
    .N_BWR(N_BWR), .BRD_N(BRD_N), .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N),
    .BRFSH_N(BRFSH_N), .BM1_N(BM1_N), .WAIT_N(WAIT_N),
    .DMA_N(DMA_N), .BUSAK_N(BUSAK_N), .OS3_N(OS3_N),
    .RST_N(RST_N), .CPRST_N(CPRST_N), .NETRST_N(NETRST_N),
    .BUSRQ_N(BUSRQ_N), .ADDRBUFEN_N(ADDRBUFEN_N), .SPINDIS_N(SPINDIS_N), .IS3_N(IS3_N),
    .BOOTROMCS_N(BOOTROMCS_N), .AUXROMCS_N(AUXROMCS_N), .AUXDECODE1_N(AUXDECODE1_N),
    .EN245_N(EN245_N), .RAS_N(RAS_N), .CAS1_N(CAS1_N), .CAS2_N(CAS2_N),
    .MUX(MUX), .RA7(RA7)
  );

  initial begin
    B_PHI = 1'b0;
    forever #150 B_PHI = ~B_PHI;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge B_PHI);
    #10;
  endtask

  task automatic idle();
    BMREQ_N = 1'b1; IORQ_N = 1'b1; N_BWR = 1'b1; BRD_N = 1'b1;
    BRFSH_N = 1'b1; BM1_N = 1'b1;
  endtask

  task automatic set_addr(input int a);
    BA15 = ((a >> 15) & 1) != 0;
    BA14 = ((a >> 14) & 1) != 0;
    BA13 = ((a >> 13) & 1) != 0;
    BA7  = ((a >> 7) & 1) != 0;
    BA6  = ((a >> 6) & 1) != 0;
  endtask

  // Expected device for an address, derived from the memory map as address ranges.
  function automatic int exp_sel(input int addr, input int mm);
    int mode;
    if (addr < 'h8000) begin
      mode = mm % 4;
      if (mode == 0) return (addr >= 'h6000) ? S_RAM : S_BOOT;
      else if (mode == 1) return S_RAM;
      else if (mode == 2) return S_AUX1;
      else return (addr < 'h2000) ? S_EN245 : S_RAM;
    end else begin
      mode = mm / 4;
      if (mode == 0) return S_RAM;
      else if (mode == 1) return S_AUX1;
      else if (mode == 2) return S_AUXROM;
      else return S_EN245;
    end
  endfunction

  task automatic chk_sel(input string tag, input int sel);
    logic [4:0] exp;
    exp = ~{sel == S_BOOT, sel == S_AUXROM, sel == S_AUX1, sel == S_EN245, sel == S_RAM};
    chk5(tag, {BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N, RAS_N}, exp);
  endtask

  // One Z80 memory cycle: decode before the edge, mux/CAS after it, mux drop at the end.
  task automatic mem_cycle(input string tag, input int addr, input bit wr);
    int sel;
    bit hi, ram;
    set_addr(addr);
    BRFSH_N = 1'b1;
    BMREQ_N = 1'b0;
    if (wr) N_BWR = 1'b0; else BRD_N = 1'b0;
    #5;
    sel = exp_sel(addr, mm_model);
    hi  = addr >= 'h8000;
    ram = sel == S_RAM;
    chk_sel({tag, "_sel"}, sel);
    chk({tag, "_mux0"}, MUX, 1'b0);
    chk({tag, "_ra7row"}, RA7, ((addr >> 7) & 1) != 0);
    edge_n(1);
    chk({tag, "_mux1"}, MUX, ram);
    chk({tag, "_cas1"}, CAS1_N, !(ram && !hi));
    chk({tag, "_cas2"}, CAS2_N, !(ram && hi));
    chk({tag, "_ra7col"}, RA7, ram ? hi : (((addr >> 7) & 1) != 0));
    idle();
    #5;
    chk({tag, "_muxoff"}, MUX, 1'b0);
  endtask

  task automatic io_write(input bit a7, input bit a6, input logic [3:0] d);
    BA7 = a7; BA6 = a6;
    {BD3, BD2, BD1, BD0} = d;
    IORQ_N = 1'b0; N_BWR = 1'b0; BM1_N = 1'b1;
    if (rst_ok && !a7 && a6) mm_model = int'(d);
    if (a7) spin_model = a6;
    if (!OS3_N) is3_model = 1'b1;
    else if (!a7 && !a6) is3_model = 1'b0;
    edge_n(1);
    idle();
  endtask

  task automatic refresh_cycle(input string tag, input int addr);
    set_addr(addr);
    BRD_N = 1'b1;
    BRFSH_N = 1'b0;
    BMREQ_N = 1'b0;
    #5;
    chk5({tag, "_sel"}, {BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N, RAS_N}, 5'b11110);
    edge_n(1);
    chk({tag, "_mux"}, MUX, 1'b0);
    chk({tag, "_cas1"}, CAS1_N, 1'b1);
    chk({tag, "_cas2"}, CAS2_N, 1'b1);
    idle();
    #5;
  endtask

  task automatic os3_pulse();
    OS3_N = 1'b0;
    is3_model = 1'b1;
    edge_n(1);
    OS3_N = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; N_CVRST = 1'b1; PBRST_N = 1'b1; WAIT_N = 1'b1;
    DMA_N = 1'b1; BUSAK_N = 1'b1; OS3_N = 1'b1;
    set_addr(0);
    {BD3, BD2, BD1, BD0} = 4'b0000;
    idle();

    // 1. Power-on reset and stretch
    edge_n(2);
    chk("por_rst", RST_N, 1'b0);
    chk("por_cprst", CPRST_N, 1'b0);
    chk("por_netrst", NETRST_N, 1'b0);
    chk("por_spindis", SPINDIS_N, 1'b1);
    chk("por_is3", IS3_N, 1'b1);
    chk("por_busrq", BUSRQ_N, 1'b1);
    chk("por_mux", MUX, 1'b0);
    RESET = 1'b0;
    edge_n(STRETCH - 1);
    chk("por_stretch_rst", RST_N, 1'b0);
    chk("por_stretch_net", NETRST_N, 1'b0);
    edge_n(1);
    chk("por_rel_rst", RST_N, 1'b1);
    chk("por_rel_cprst", CPRST_N, 1'b1);
    chk("por_rel_net", NETRST_N, 1'b1);
    chk5("idle_sel", {BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N, RAS_N}, 5'b11111);
    chk("idle_cas1", CAS1_N, 1'b1);
    chk("idle_cas2", CAS2_N, 1'b1);

    // 2. Game reset leaves AdamNET alone; computer reset hits everything
    N_CVRST = 1'b0;
    #5;
    chk("cv_rst", RST_N, 1'b0);
    chk("cv_cprst", CPRST_N, 1'b0);
    chk("cv_net", NETRST_N, 1'b1);
    #995;
    N_CVRST = 1'b1;
    edge_n(STRETCH - 1);
    chk("cv_hold_rst", RST_N, 1'b0);
    chk("cv_hold_net", NETRST_N, 1'b1);
    edge_n(1);
    chk("cv_rel_rst", RST_N, 1'b1);
    chk("cv_rel_cprst", CPRST_N, 1'b1);
    PBRST_N = 1'b0;
    #5;
    chk("pb_rst", RST_N, 1'b0);
    chk("pb_net", NETRST_N, 1'b0);
    #995;
    PBRST_N = 1'b1;
    edge_n(STRETCH - 1);
    chk("pb_hold_rst", RST_N, 1'b0);
    chk("pb_hold_net", NETRST_N, 1'b0);
    edge_n(1);
    chk("pb_rel_rst", RST_N, 1'b1);
    chk("pb_rel_cprst", CPRST_N, 1'b1);
    chk("pb_rel_net", NETRST_N, 1'b1);

    // 3. Boot ROM, lower RAM bank, upper RAM bank (RA7 row/column switch)
    mem_cycle("rd_boot", 'h0000, 1'b0);
    mem_cycle("rd_ram_lo", 'h6080, 1'b0);
    mem_cycle("wr_ram_hi", 'h8000, 1'b1);

    // 4. Memory-map write then OS7 and expansion ROM
    io_write(1'b0, 1'b1, 4'b1011);
    mem_cycle("mm_os7", 'h0000, 1'b0);
    mem_cycle("mm_auxrom", 'h8000, 1'b0);
    mem_cycle("mm_ramlo", 'h4000, 1'b1);

    // 5. Refresh
    refresh_cycle("rfsh", 'h6000);

    // Reset in the middle of DMA clears the map and aborts the request
    DMA_N = 1'b0;
    edge_n(1);
    chk("dma_req", BUSRQ_N, 1'b0);
    N_CVRST = 1'b0;
    #5;
    chk("mid_rst", RST_N, 1'b0);
    edge_n(1);
    chk("mid_busrq", BUSRQ_N, 1'b1);
    mm_model = 0;
    N_CVRST = 1'b1;
    rst_ok = 1'b0;
    io_write(1'b0, 1'b1, 4'b1111);
    rst_ok = 1'b1;
    chk("mid_busrq_hold", BUSRQ_N, 1'b1);
    DMA_N = 1'b1;
    edge_n(STRETCH - 1);
    chk("mid_rel_rst", RST_N, 1'b1);
    mem_cycle("mid_boot", 'h0000, 1'b0);

    // 6. DMA handshake, IS3/OS3, spinner disable
    DMA_N = 1'b0;
    #5;
    chk("dma_pre", BUSRQ_N, 1'b1);
    edge_n(1);
    chk("dma_busrq", BUSRQ_N, 1'b0);
    BUSAK_N = 1'b0;
    #5;
    chk("dma_abuf_off", ADDRBUFEN_N, 1'b1);
    BUSAK_N = 1'b1;
    #5;
    chk("dma_abuf_on", ADDRBUFEN_N, 1'b0);
    DMA_N = 1'b1;
    edge_n(1);
    chk("dma_release", BUSRQ_N, 1'b1);
    io_write(1'b0, 1'b0, 4'b0000);
    chk("is3_set", IS3_N, is3_model);
    os3_pulse();
    chk("is3_clr", IS3_N, is3_model);
    OS3_N = 1'b0;
    io_write(1'b0, 1'b0, 4'b0000);
    OS3_N = 1'b1;
    chk("is3_clr_wins", IS3_N, is3_model);
    io_write(1'b1, 1'b0, 4'b0000);
    chk("spin_off", SPINDIS_N, spin_model);
    io_write(1'b1, 1'b1, 4'b0000);
    chk("spin_on", SPINDIS_N, spin_model);

    // Randomized bus traffic against the map-level model
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        io_write($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)));
        chk("rnd_spin", SPINDIS_N, spin_model);
        chk("rnd_is3", IS3_N, is3_model);
      end else if (op <= 7) begin
        mem_cycle("rnd_mem", int'($urandom_range(0, 65535)), $urandom_range(0, 1) != 0);
      end else if (op == 8) begin
        refresh_cycle("rnd_rfsh", int'($urandom_range(0, 65535)));
      end else begin
        os3_pulse();
        chk("rnd_os3", IS3_N, is3_model);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mioc_top.md
Name: mioc_top

Overview:
Memory/IO controller for the ADAM Z80 board. It generates system and AdamNET resets and latches the memory-map register. It decodes chip selects for boot ROM, internal DRAM, expansion RAM/ROM and cartridge, and produces DRAM RAS/MUX/CAS timing. It also arbitrates 6801 DMA bus requests and the IS3/OS3 handshake.

Parameters:
RST_STRETCH, 4, number of B_PHI cycles that reset outputs stay asserted after all reset sources release.

Ports:
B_PHI in 1 Z80 clock; all registers update on its rising edge.
RESET in 1 asynchronous active-high power-on reset.
N_CVRST, PBRST_N in 1 each: active-low game reset and computer reset requests.
BA15, BA14, BA13, BA7, BA6 in 1 each: buffered address bits.
BD0..BD3 in 1 each: buffered data bits.
N_BWR, BRD_N, BMREQ_N, IORQ_N, BRFSH_N, BM1_N, WAIT_N in 1 each: active-low Z80 strobes.
DMA_N, BUSAK_N, OS3_N in 1 each: active-low DMA request, bus acknowledge, and 6801 OS3.
RST_N, CPRST_N, NETRST_N out 1 each: active-low resets.
BUSRQ_N, ADDRBUFEN_N, SPINDIS_N, IS3_N out 1 each: active-low bus request, address-buffer enable, spinner disable, and IS3 to 6801.
BOOTROMCS_N, AUXROMCS_N, AUXDECODE1_N, EN245_N out 1 each: active-low chip selects.
RAS_N, CAS1_N, CAS2_N, MUX, RA7 out 1 each: DRAM control.

Behaviour:
- Reset state while RESET=1: every registered output is at its inactive level except the reset outputs.
  - RST_N=0, CPRST_N=0, NETRST_N=0.
  - MEMMAP=4'b0000.
  - SPINDIS_N=1, IS3_N=1, BUSRQ_N=1, MUX=0.
- Reset stretch counter:
  - Reloaded with RST_STRETCH while N_CVRST=0, PBRST_N=0 or RESET=1; decrements to 0 otherwise.
  - RST_N=0 while any source is active or the counter is nonzero.
  - CPRST_N equals RST_N.
  - NETRST_N=0 only from PBRST_N or RESET (its own counter, same stretch). N_CVRST does not reset AdamNET.
- I/O write strobe IOW = !IORQ_N & !N_BWR & BM1_N.
- MEMMAP write: IOW with BA7=0, BA6=1 latches {BD3..BD0} on the B_PHI edge. Write while RST_N=0 is ignored.
- SPINDIS_N: IOW with BA7=1, BA6=0 sets it 0; IOW with BA7=1, BA6=1 sets it 1.
- IS3_N: IOW with BA7=0, BA6=0 sets IS3_N=0. It is cleared to 1 on the edge where OS3_N=0; clear wins if both occur together.
- Memory decode: active only when MREQ = !BMREQ_N & BRFSH_N; all selects are combinational.
  - Lower half (BA15=0), MEMMAP[1:0]:
    - 00: BA14..13 != 11 selects BOOTROMCS_N; 0x6000-0x7FFF selects internal RAM.
    - 01: internal RAM.
    - 10: AUXDECODE1_N.
    - 11: 0x0000-0x1FFF selects EN245_N (OS7); the rest is internal RAM.
  - Upper half (BA15=1), MEMMAP[3:2]: 00 internal RAM, 01 AUXDECODE1_N, 10 AUXROMCS_N, 11 EN245_N.
- DRAM:
  - RAS_N=0 when (MREQ & internal RAM) or (!BMREQ_N & !BRFSH_N), the latter being refresh to both banks.
  - MUX sets on the first B_PHI edge with RAS_N=0 and BRFSH_N=1. MUX clears asynchronously when BMREQ_N=1.
  - RA7 = MUX ? BA15 : BA7.
  - CAS1_N=0 when MUX & BA15=0 & (!BRD_N | !N_BWR). CAS2_N is the same with BA15=1.
  - Refresh never asserts CAS.
  - WAIT_N has no effect; all strobes simply track BMREQ_N.
- DMA:
  - BUSRQ_N is registered !DMA_N inverted, i.e. it follows DMA_N with one cycle of latency.
  - ADDRBUFEN_N = !BUSAK_N, combinational: buffers are disabled while the bus is granted.
  - Releasing DMA_N deasserts BUSRQ_N on the next edge.
- Reset mid-operation: a reset source going active forces the reset outputs low immediately (asynchronous), clears MEMMAP and aborts DMA.

Test Plan:
1. RESET pulse, then idle with all strobes high -> RST_N goes 1 four clocks after RESET drops. All chip selects, RAS_N, CAS1_N and CAS2_N read 1; MUX=0.
2. N_CVRST low 1000 ns at a 300 ns clock period -> RST_N=0 and CPRST_N=0 until 4 edges after release; NETRST_N stays 1. Then PBRST_N low 1000 ns -> all three resets are 0, releasing 4 edges later.
3. Memory read at BA15..13=000 with MEMMAP=0 -> BOOTROMCS_N=0. At 011 -> RAS_N=0, then MUX=1 on the next edge, then CAS1_N=0. At BA15=1 -> CAS2_N path, RA7 switches from BA7 to BA15.
4. IO write with BA7=0, BA6=1 and BD=4'b1011 -> MEMMAP=1011. A read at 0x0000 asserts EN245_N; a read at 0x8000 asserts AUXROMCS_N.
5. Refresh (BMREQ_N=0, BRFSH_N=0) -> RAS_N=0; MUX, CAS1_N and CAS2_N stay inactive.
6. DMA_N=0 -> BUSRQ_N=0 after 1 edge. BUSAK_N=0 -> ADDRBUFEN_N=1. IS3_N set by a write to BA7=0, BA6=0, cleared by an OS3_N low pulse.
